// File: rtl/conbus_sched.sv
// conbus_sched: registered round-robin arbiter with fairness quantum and bus
// watchdog for the shared Wishbone interconnect.
//
// Ports:
//   sys_clk  - system clock, rising edge
//   sys_rst  - synchronous active-high reset
//   req      - per-master CYC requests
//   bus_stb  - STB of the shared bus (granted master)
//   bus_ack  - OR of all slave acks
//   bus_cti  - CTI of the shared bus
//   gnt      - registered one-hot grant
//   gnt_id   - registered binary index of gnt
//   wdt_err  - one-cycle timeout strobe (acts as an error ack)
//   busy     - granted master's req is high
//
// Handshake: a beat completes in any cycle where bus_stb and bus_ack are both
// high; wdt_err completes the stalled beat in the cycle it is high. A transfer
// boundary is a completed beat with bus_cti 3'b000 (classic) or 3'b111 (end of
// burst); only there may the grant be taken from a still-requesting owner.
module conbus_sched #(
    parameter int N_MASTERS  = 3,
    parameter int QUANTUM    = 16,
    parameter int WDT_CYCLES = 255,
    localparam int ID_W      = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_MASTERS-1:0] req,
    input  logic                 bus_stb,
    input  logic                 bus_ack,
    input  logic [2:0]           bus_cti,
    output logic [N_MASTERS-1:0] gnt,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 wdt_err,
    output logic                 busy
);

    typedef enum logic {PARK, OWN} state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;
    logic [N_MASTERS-1:0] gnt_q;
    logic [15:0]          q_cnt;
    logic [15:0]          wdt_cnt;
    logic                 wdt_err_q;

    logic                 found;
    logic [ID_W-1:0]      scan_id;
    logic                 owner_req;
    logic                 others;
    logic                 ev;
    logic                 boundary;
    logic [16:0]          q_eff;
    logic                 preempt;
    logic                 stall;
    logic                 wdt_hit;

    // Round-robin scan starting just after the current owner; the owner itself
    // is visited last so it only wins when nobody else is asking.
    always_comb begin
        int idx;
        found   = 1'b0;
        scan_id = gnt_id_q;
        idx     = 0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            idx = (int'(gnt_id_q) + i) % N_MASTERS;
            if (!found && req[idx]) begin
                found   = 1'b1;
                scan_id = ID_W'(idx);
            end
        end
    end

    assign owner_req = req[gnt_id_q];
    assign others    = |(req & ~gnt_q);
    assign ev        = bus_ack | wdt_err_q;
    assign boundary  = ev && (bus_cti == 3'b000 || bus_cti == 3'b111);
    // Include the current cycle's ack so the quantum-th ack is itself the
    // preemption point.
    assign q_eff     = {1'b0, q_cnt} + {16'd0, ev};
    assign preempt   = (state_q == OWN) && owner_req && (QUANTUM != 0) &&
                       (q_eff >= 17'(QUANTUM)) && boundary && others;

    // FSM next-state / next-grant
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        case (state_q)
            PARK: begin
                if (found) begin
                    gnt_id_d = scan_id;
                    state_d  = OWN;
                end
            end
            OWN: begin
                if (!owner_req || preempt) begin
                    if (found) begin
                        gnt_id_d = scan_id;
                        state_d  = OWN;
                    end else begin
                        state_d  = PARK;
                    end
                end
            end
            default: state_d = PARK;
        endcase
    end

    assign stall   = bus_stb && !bus_ack;
    assign wdt_hit = (WDT_CYCLES != 0) && stall &&
                     (wdt_cnt == 16'(WDT_CYCLES - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= PARK;
            gnt_id_q  <= '0;
            gnt_q     <= N_MASTERS'(1);
            q_cnt     <= '0;
            wdt_cnt   <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            gnt_q    <= N_MASTERS'(1) << gnt_id_d;

            if (gnt_id_d != gnt_id_q)
                q_cnt <= '0;
            else if (state_q == OWN && ev && q_cnt < 16'(QUANTUM))
                q_cnt <= q_cnt + 16'd1;

            if (!stall || wdt_hit || WDT_CYCLES == 0)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + 16'd1;

            wdt_err_q <= wdt_hit;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign wdt_err = wdt_err_q;
    assign busy    = req[gnt_id_q];

endmodule

// File: tb/tb_conbus_sched.sv
module tb_conbus_sched;

  localparam int N = 3;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic [N-1:0] req;
  logic         bus_stb;
  logic         bus_ack;
  logic [2:0]   bus_cti;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         wdt_err;
  logic         busy;

  int vectors = 0;
  int errs    = 0;

  conbus_sched #(.N_MASTERS(N), .QUANTUM(4), .WDT_CYCLES(10)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .req     (req),
    .bus_stb (bus_stb),
    .bus_ack (bus_ack),
    .bus_cti (bus_cti),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .wdt_err (wdt_err),
    .busy    (busy)
  );

  // clock
  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic [N-1:0] eg, input logic [1:0] eid);
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_id"}, 32'(gnt_id), 32'(eid));
  endtask

  initial begin
    // reset with masters 1 and 2 requesting
    sys_rst = 1'b1; req = 3'b110; bus_stb = 1'b0; bus_ack = 1'b0; bus_cti = 3'b000;
    tick(); tick();
    chk_gnt("rst", 3'b001, 2'd0);
    chk("rst_wdt", 32'(wdt_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    tick();
    chk_gnt("rst_rel", 3'b010, 2'd1);
    chk("rst_rel_busy", 32'(busy), 32'd1);

    // quantum: master 0 owns, masters 0 and 2 stream single transfers
    sys_rst = 1'b1; req = 3'b001;
    tick();
    sys_rst = 1'b0;
    tick();
    chk_gnt("q_own0", 3'b001, 2'd0);
    req = 3'b101; bus_stb = 1'b1; bus_ack = 1'b1; bus_cti = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_gnt("q_m0_hold", 3'b001, 2'd0);
    end
    tick();
    chk_gnt("q_pre_to2", 3'b100, 2'd2);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_gnt("q_m2_hold", 3'b100, 2'd2);
    end
    tick();
    chk_gnt("q_pre_to0", 3'b001, 2'd0);

    // burst: hand bus to master 1 by dropping master 0
    req = 3'b010; bus_stb = 1'b0; bus_ack = 1'b0;
    tick();
    chk_gnt("b_own1", 3'b010, 2'd1);
    req = 3'b011; bus_stb = 1'b1; bus_ack = 1'b1; bus_cti = 3'b010;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_gnt("b_midburst", 3'b010, 2'd1);
    end
    bus_cti = 3'b111;
    tick();
    chk_gnt("b_end_pre", 3'b001, 2'd0);

    // watchdog: stall from cycle 1
    req = 3'b001; bus_stb = 1'b1; bus_ack = 1'b0; bus_cti = 3'b000;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("w_quiet", 32'(wdt_err), 32'd0);
    end
    tick();
    chk("w_fire", 32'(wdt_err), 32'd1);
    tick();
    chk("w_one_wide", 32'(wdt_err), 32'd0);
    for (int i = 12; i <= 19; i++) begin
      tick();
      chk("w_restart_quiet", 32'(wdt_err), 32'd0);
    end
    tick();
    chk("w_refire", 32'(wdt_err), 32'd1);
    bus_stb = 1'b0;
    tick();
    chk("w_idle", 32'(wdt_err), 32'd0);
    // ack arrives in the threshold cycle
    bus_stb = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    bus_ack = 1'b1;
    tick();
    chk("w_ack_thr", 32'(wdt_err), 32'd0);
    bus_ack = 1'b0; bus_stb = 1'b0;
    tick();
    chk("w_ack_thr_after", 32'(wdt_err), 32'd0);
    chk_gnt("w_owner", 3'b001, 2'd0);

    // parking: owner drops with nobody else asking
    req = 3'b000;
    #1;
    chk("p_busy_now", 32'(busy), 32'd0);
    tick();
    chk_gnt("p_parked", 3'b001, 2'd0);
    chk("p_busy", 32'(busy), 32'd0);
    req = 3'b100;
    #1;
    chk_gnt("p_before", 3'b001, 2'd0);
    tick();
    chk_gnt("p_grant2", 3'b100, 2'd2);
    chk("p_busy2", 32'(busy), 32'd1);

    // reset during a wait state at gnt=100
    bus_stb = 1'b1; bus_ack = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_gnt("r_pre", 3'b100, 2'd2);
    sys_rst = 1'b1;
    tick();
    chk_gnt("r_mid", 3'b001, 2'd0);
    chk("r_mid_wdt", 32'(wdt_err), 32'd0);
    sys_rst = 1'b0;
    tick();
    chk_gnt("r_resume", 3'b100, 2'd2);
    chk("r_q1", 32'(wdt_err), 32'd0);
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("r_wdt_cleared", 32'(wdt_err), 32'd0);
    end
    tick();
    chk("r_wdt_fire", 32'(wdt_err), 32'd1);
    bus_stb = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
